spi_xip_reader: RTL and testbench
=================================

Name: spi_xip_reader

Overview:
- Synthesizable SPI flash read master, directly upstream of the SPI flash device.
- Converts CPU word-read requests (valid/ready/addr/rdata) into flash read transactions on csb/clk/io0-3.
- Supports single-SPI read (0x03) and quad I/O read (0xEB); keeps csb low so sequential reads continue without a new command.
- Sends power-up command 0xAB after reset.

Parameters:
- DUMMY_CYCLES, 8, flash clocks with io tri-stated between the 0xEB mode byte and data; must equal flash latency.
- CSB_IDLE, 2, minimum clk cycles csb is held high between transactions.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- valid  input  1  read request
- ready  output  1  one-cycle pulse: rdata valid, request consumed
- addr  input  24  byte address; addr[1:0] ignored (word aligned)
- rdata  output  32  little-endian word: byte at addr in [7:0]
- cfg_quad  input  1  0 = 0x03 single, 1 = 0xEB quad; sampled at transaction start
- flash_csb  output  1  chip select, active low
- flash_clk  output  1  SPI clock, mode 0
- flash_io_oe  output  4  per-line output enable
- flash_io_do  output  4  output data; bit0 = MOSI in single mode
- flash_io_di  input  4  input data; bit1 = MISO in single mode

Behaviour:
Reset values:
- flash_csb=1, flash_clk=0, flash_io_oe=0, flash_io_do=0, ready=0, rdata=0.
- State WAKE. Reset mid-transaction aborts immediately with the same values.

SPI bit timing:
- Each flash clock is 2 clk cycles: phase L (flash_clk=0; do/oe update at entry), then phase H (flash_clk=1).
- di is sampled on the clk edge that ends phase H.
- Data lines only change while flash_clk=0.

Bit and nibble order:
- MSB first.
- Quad nibble mapping: io3..io0 = bits 7..4, then bits 3..0.

States:
- WAKE: csb low, shift 0xAB on io0 (8 flash clocks), csb high for CSB_IDLE cycles, then IDLE. ready stays 0 and valid is ignored throughout.
- IDLE:
  - On valid with csb low, addr[23:2]==next_addr, and cfg_quad==cur_quad → DATA (continuation, no command).
  - On valid otherwise: if csb is low, raise csb for CSB_IDLE cycles first, then → CMD.
- CMD: csb low, 8 bits of 0x03 or 0xEB on io0 only (oe=0001).
- ADDR:
  - Single: 24 bits on io0.
  - Quad: 6 nibbles on io3..0 (oe=1111).
- MODE (quad only): 2 nibbles of 0x00, oe=1111. Flash-side XIP is not used.
- DUMMY (quad only): DUMMY_CYCLES flash clocks, oe=0000.
- DATA:
  - Single: 32 bits sampled from io1, oe=0000.
  - Quad: 8 nibbles from io3..0, oe=0000.
  - Bytes are assembled little-endian.
- DONE:
  - ready=1 for exactly one cycle; rdata updated in the same cycle and held until the next ready.
  - next_addr = addr[23:2]+1, wrapping 0x3FFFFF → 0x000000.
  - csb stays low → IDLE. flash_clk stays 0 while idle.

Latency, valid to ready, fresh transaction from csb high:
- Single: 64 flash clocks = 128 clk + 2.
- Quad: (8+6+2+DUMMY_CYCLES+8) flash clocks = 64 clk + 2.
- Continuation: single 64+2 clk; quad 16+2 clk.

Handshake:
- valid and addr are held by the requester until ready.
- A deasserted valid before ready is a protocol violation; the block completes the transfer anyway.
- Back-to-back: valid in the same cycle as ready is not accepted until the next cycle.

Boundaries:
- Address wrap at 16 MB follows the flash's internal wrap, so a continuation across 0xFFFFFC→0x000000 is legal.
- A cfg_quad change while idle with csb low forces a fresh transaction.

Decomposition:
- Package spi_xip_pkg:
  - State enum.
  - Command constants: CMD_WAKE=8'hAB, CMD_READ=8'h03, CMD_QREAD=8'hEB, MODE_BYTE=8'h00.
- Sub-module spi_xip_shifter:
  - 32-bit shift register with 1- or 4-bit shift width, bit counter and flash_clk phase generator.
  - Reports shift-done to the FSM.

Test Plan:
1. Reset release with no requests → one csb-low window with exactly 8 flash clocks carrying 0xAB on io0, then csb high; ready never pulses.
2. Flash image bytes 00..0F, cfg_quad=0, read 0x000004 → command 0x03, address 000004, rdata=0x07060504, ready 130 clk after valid.
3. Same image, cfg_quad=1, read 0x000008 → io shows EB, 00 00 08, mode 00, 8 tri-stated flash clocks; rdata=0x0B0A0908.
4. Quad read 0x000000 then 0x000004 → csb stays low and no command on the second read; rdata=0x07060504, 18 clk latency.
5. Quad read 0x000000 then 0x000010 → csb high for ≥2 clk and a new 0xEB transaction; rdata=0x13121110.
6. Reset asserted mid-DATA → next cycle csb=1 and oe=0; the wake sequence repeats and a subsequent read returns correct data.

Source files
------------

// File: rtl/spi_xip_pkg.sv
// Shared types and command constants for the SPI execute-in-place read master.
package spi_xip_pkg;

    typedef enum logic [3:0] {
        ST_WAKE,
        ST_WAKE_SH,
        ST_WAKE_GAP,
        ST_IDLE,
        ST_GAP,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_WAKE  = 8'hAB;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'hEB;
    localparam logic [7:0] MODE_BYTE = 8'h00;

    // One serial phase: left-aligned payload, flash clock count, lane width, line enables.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  nclk;
        logic        quad;
        logic [3:0]  oe;
    } shift_plan_t;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_shifter.sv
// Serial engine: 32-bit MSB-first shift register, 1- or 4-lane, with the two-cycle flash clock.
module spi_xip_shifter
    import spi_xip_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] load,
    input  logic [7:0]  nclk,
    input  logic        quad,
    input  logic [3:0]  io_di,
    output logic        flash_clk,
    output logic [3:0]  io_do,
    output logic [31:0] shreg,
    output logic        done
);

    logic       busy;
    logic       phase_h;
    logic       wide;
    logic [7:0] cnt;

    // Combinational so the controller can chain the next phase on the very edge that ends this one.
    assign done = busy && phase_h && (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            phase_h   <= 1'b0;
            cnt       <= 8'd0;
            flash_clk <= 1'b0;
            io_do     <= 4'b0000;
        end else if (start) begin
            busy      <= 1'b1;
            phase_h   <= 1'b0;
            wide      <= quad;
            cnt       <= nclk - 8'd1;
            shreg     <= load;
            flash_clk <= 1'b0;
            io_do     <= quad ? load[31:28] : {3'b000, load[31]};
        end else if (busy) begin
            if (!phase_h) begin
                phase_h   <= 1'b1;
                flash_clk <= 1'b1;
            end else begin
                // End of phase H: sample the input lanes and present the next output bits.
                phase_h   <= 1'b0;
                flash_clk <= 1'b0;
                cnt       <= cnt - 8'd1;
                if (wide) begin
                    shreg <= {shreg[27:0], io_di};
                    io_do <= shreg[27:24];
                end else begin
                    shreg <= {shreg[30:0], io_di[1]};
                    io_do <= {3'b000, shreg[30]};
                end
                if (cnt == 8'd0) begin
                    busy  <= 1'b0;
                    io_do <= 4'b0000;
                end
            end
        end
    end

endmodule

// File: rtl/spi_xip_reader.sv
// SPI flash word reader: wakes the flash, then serves word reads in single (0x03) or quad (0xEB)
// mode, keeping chip select low so sequential words stream without a new command.
module spi_xip_reader
    import spi_xip_pkg::*;
#(
    parameter int DUMMY_CYCLES = 8,
    parameter int CSB_IDLE     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [23:0] addr,
    output logic [31:0] rdata,
    input  logic        cfg_quad,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic [3:0]  flash_io_oe,
    output logic [3:0]  flash_io_do,
    input  logic [3:0]  flash_io_di
);

    state_t      state;
    state_t      launch_st;
    logic [21:0] cur_addr;
    logic [21:0] next_addr;
    logic        cur_quad;
    logic [7:0]  gap_cnt;
    logic        accept;
    logic        cont;
    logic        launch;
    logic        launch_quad;
    logic        sh_done;
    logic [31:0] shreg;
    shift_plan_t plan;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^addr[1:0];

    function automatic shift_plan_t plan_for(input state_t st, input logic q, input logic [21:0] a);
        shift_plan_t p;
        p = '{32'h0, 8'd0, 1'b0, 4'b0000};
        case (st)
            ST_WAKE_SH: p = '{{CMD_WAKE, 24'h0}, 8'd8, 1'b0, 4'b0001};
            ST_CMD:     p = '{{(q ? CMD_QREAD : CMD_READ), 24'h0}, 8'd8, 1'b0, 4'b0001};
            ST_ADDR:    p = '{{a, 2'b00, 8'h00}, (q ? 8'd6 : 8'd24), q, (q ? 4'b1111 : 4'b0001)};
            ST_MODE:    p = '{{MODE_BYTE, 24'h0}, 8'd2, 1'b1, 4'b1111};
            ST_DUMMY:   p = '{32'h0, 8'(DUMMY_CYCLES), 1'b1, 4'b0000};
            ST_DATA:    p = '{32'h0, (q ? 8'd8 : 8'd32), q, 4'b0000};
            default:    p = '{32'h0, 8'd0, 1'b0, 4'b0000};
        endcase
        return p;
    endfunction

    // Decide whether a serial phase starts on this edge and which one.
    always_comb begin
        accept      = (state == ST_IDLE) && valid && !ready;
        cont        = accept && !flash_csb && (addr[23:2] == next_addr) && (cfg_quad == cur_quad);
        launch      = 1'b0;
        launch_st   = ST_IDLE;
        launch_quad = cur_quad;
        case (state)
            ST_WAKE: begin
                launch    = 1'b1;
                launch_st = ST_WAKE_SH;
            end
            ST_IDLE: begin
                if (accept && (flash_csb || cont)) begin
                    launch      = 1'b1;
                    launch_st   = cont ? ST_DATA : ST_CMD;
                    launch_quad = cfg_quad;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    launch    = 1'b1;
                    launch_st = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sh_done) begin
                    launch    = 1'b1;
                    launch_st = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (sh_done) begin
                    launch    = 1'b1;
                    launch_st = cur_quad ? ST_MODE : ST_DATA;
                end
            end
            ST_MODE: begin
                if (sh_done) begin
                    launch    = 1'b1;
                    launch_st = (DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
                end
            end
            ST_DUMMY: begin
                if (sh_done) begin
                    launch    = 1'b1;
                    launch_st = ST_DATA;
                end
            end
            default: ;
        endcase
        plan = plan_for(launch_st, launch_quad, cur_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAKE;
            flash_csb   <= 1'b1;
            flash_io_oe <= 4'b0000;
            ready       <= 1'b0;
            rdata       <= 32'h0;
            gap_cnt     <= 8'd0;
            cur_quad    <= 1'b0;
            cur_addr    <= 22'd0;
            next_addr   <= 22'd0;
        end else begin
            ready <= 1'b0;
            if (launch) begin
                state       <= launch_st;
                flash_csb   <= 1'b0;
                flash_io_oe <= plan.oe;
            end
            case (state)
                ST_WAKE_SH: begin
                    if (sh_done) begin
                        state       <= ST_WAKE_GAP;
                        flash_csb   <= 1'b1;
                        flash_io_oe <= 4'b0000;
                        gap_cnt     <= 8'(CSB_IDLE - 1);
                    end
                end
                ST_WAKE_GAP: begin
                    if (gap_cnt == 8'd0) state <= ST_IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                ST_IDLE: begin
                    if (accept) begin
                        cur_addr <= addr[23:2];
                        cur_quad <= cfg_quad;
                        // A non-sequential request while selected must first deselect the flash.
                        if (!flash_csb && !cont) begin
                            state     <= ST_GAP;
                            flash_csb <= 1'b1;
                            gap_cnt   <= 8'(CSB_IDLE - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                ST_DATA: begin
                    if (sh_done) begin
                        state       <= ST_DONE;
                        flash_io_oe <= 4'b0000;
                    end
                end
                ST_DONE: begin
                    ready     <= 1'b1;
                    rdata     <= swap_bytes(shreg);
                    next_addr <= cur_addr + 22'd1;
                    state     <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    spi_xip_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (launch),
        .load      (plan.data),
        .nclk      (plan.nclk),
        .quad      (plan.quad),
        .io_di     (flash_io_di),
        .flash_clk (flash_clk),
        .io_do     (flash_io_do),
        .shreg     (shreg),
        .done      (sh_done)
    );

endmodule

// File: tb/tb_spi_xip_reader.sv
// Directed bench for spi_xip_reader with a behavioural SPI flash and an rdata scoreboard.
module tb_spi_xip_reader;

    localparam int DUMMY = 8;
    localparam int GAP   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [23:0] addr = 24'h0;
    logic        cfg_quad = 1'b0;
    logic        ready;
    logic [31:0] rdata;
    logic        flash_csb;
    logic        flash_clk;
    logic [3:0]  flash_io_oe;
    logic [3:0]  flash_io_do;
    logic [3:0]  flash_io_di = 4'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_xip_reader #(.DUMMY_CYCLES(DUMMY), .CSB_IDLE(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready       (ready),
        .addr        (addr),
        .rdata       (rdata),
        .cfg_quad    (cfg_quad),
        .flash_csb   (flash_csb),
        .flash_clk   (flash_clk),
        .flash_io_oe (flash_io_oe),
        .flash_io_do (flash_io_do),
        .flash_io_di (flash_io_di)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] img(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // Behavioural flash
    logic [7:0]  f_cmd  = 8'h00;
    logic [23:0] f_addr = 24'h0;
    logic [7:0]  f_mode = 8'hFF;
    int          fcnt = 0;
    int          csb_falls = 0;
    int          wake_seen = 0;
    logic [7:0]  rise_cmd = 8'h00;
    int          rise_clks = 0;
    int          io_bad = 0;
    int          nk;
    logic [7:0]  nb;

    always @(negedge flash_csb) begin
        csb_falls++;
        fcnt   = 0;
        f_cmd  = 8'h00;
        f_addr = 24'h0;
        f_mode = 8'hFF;
    end

    always @(posedge flash_csb) begin
        rise_cmd  = f_cmd;
        rise_clks = fcnt;
        if (f_cmd == 8'hAB && fcnt == 8) wake_seen++;
    end

    always @(posedge flash_clk) begin
        if (flash_csb === 1'b0) begin
            if (fcnt < 8) begin
                f_cmd = {f_cmd[6:0], flash_io_do[0]};
                if (flash_io_oe !== 4'b0001 || flash_io_do[3:1] !== 3'b000) io_bad++;
            end else if (f_cmd == 8'h03) begin
                if (fcnt < 32) begin
                    f_addr = {f_addr[22:0], flash_io_do[0]};
                    if (flash_io_oe !== 4'b0001) io_bad++;
                end else if (flash_io_oe !== 4'b0000) io_bad++;
            end else if (f_cmd == 8'hEB) begin
                if (fcnt < 14) begin
                    f_addr = {f_addr[19:0], flash_io_do};
                    if (flash_io_oe !== 4'b1111) io_bad++;
                end else if (fcnt < 16) begin
                    f_mode = {f_mode[3:0], flash_io_do};
                    if (flash_io_oe !== 4'b1111) io_bad++;
                end else if (flash_io_oe !== 4'b0000) io_bad++;
            end
            fcnt++;
        end
    end

    always @(negedge flash_clk) begin
        if (flash_csb === 1'b0) begin
            if (f_cmd == 8'h03 && fcnt >= 32) begin
                nk = fcnt - 32;
                nb = img(f_addr + 24'(nk / 8));
                flash_io_di = {2'b00, nb[7 - (nk % 8)], 1'b0};
            end else if (f_cmd == 8'hEB && fcnt >= 16 + DUMMY) begin
                nk = fcnt - 16 - DUMMY;
                nb = img(f_addr + 24'(nk / 2));
                flash_io_di = (nk % 2 == 0) ? nb[7:4] : nb[3:0];
            end
        end
    end

    // Line-stability and chip-select high-time monitors
    logic [3:0] p_do = 4'h0;
    logic [3:0] p_oe = 4'h0;
    int         line_viol = 0;
    int         hi_cnt = 0;
    int         last_hi = 0;

    always @(negedge clk) begin
        if (flash_clk === 1'b1 && (flash_io_do !== p_do || flash_io_oe !== p_oe)) line_viol++;
        p_do = flash_io_do;
        p_oe = flash_io_oe;
    end

    always @(posedge clk) begin
        if (flash_csb === 1'b1) hi_cnt++;
        else if (hi_cnt != 0) begin
            last_hi = hi_cnt;
            hi_cnt  = 0;
        end
    end

    // Scoreboard
    logic [31:0] exp_q[$];
    int          pulses = 0;
    int          n_reads = 0;

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            pulses++;
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
        end
    end

    task automatic do_read(input string tag, input logic [23:0] a, input logic q, input int exp_lat);
        int          cyc;
        logic [23:0] w;
        cyc = 0;
        w   = {a[23:2], 2'b00};
        exp_q.push_back({img(24'(w + 24'd3)), img(24'(w + 24'd2)), img(24'(w + 24'd1)), img(w)});
        n_reads++;
        @(negedge clk);
        valid    = 1'b1;
        addr     = a;
        cfg_quad = q;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (ready !== 1'b1 && cyc < 400);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    int falls0;

    initial begin
        // Reset state
        wait_cycles(3);
        #1;
        check("rst_csb", 32'(flash_csb), 32'd1);
        check("rst_fclk", 32'(flash_clk), 32'd0);
        check("rst_oe", 32'(flash_io_oe), 32'd0);
        check("rst_do", 32'(flash_io_do), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Wake command with no requests
        wait_cycles(40);
        #1;
        check("wake_cmd", 32'(rise_cmd), 32'hAB);
        check("wake_clks", 32'(rise_clks), 32'd8);
        check("wake_count", 32'(wake_seen), 32'd1);
        check("wake_csb_windows", 32'(csb_falls), 32'd1);
        check("wake_csb_high", 32'(flash_csb), 32'd1);
        check("wake_no_ready", 32'(pulses), 32'd0);

        // Single read, fresh from csb high
        do_read("single_04", 24'h000004, 1'b0, 130);
        check("single_cmd", 32'(f_cmd), 32'h03);
        check("single_addr", 32'(f_addr), 32'h000004);

        // Quad read; mode change while selected forces a new transaction
        falls0 = csb_falls;
        do_read("quad_08", 24'h000008, 1'b1, 66 + GAP);
        check("quad_cmd", 32'(f_cmd), 32'hEB);
        check("quad_addr", 32'(f_addr), 32'h000008);
        check("quad_mode", 32'(f_mode), 32'h00);
        check("quad_new_window", 32'(csb_falls - falls0), 32'd1);
        check("quad_gap", 32'(last_hi >= GAP), 32'd1);

        // Sequential quad continuation
        do_read("quad_00", 24'h000000, 1'b1, 66 + GAP);
        falls0 = csb_falls;
        do_read("quad_cont_04", 24'h000004, 1'b1, 18);
        check("cont_no_cmd", 32'(csb_falls - falls0), 32'd0);

        // Non-sequential quad reads
        do_read("quad_00b", 24'h000000, 1'b1, 66 + GAP);
        falls0 = csb_falls;
        do_read("quad_10", 24'h000010, 1'b1, 66 + GAP);
        check("jump_new_window", 32'(csb_falls - falls0), 32'd1);
        check("jump_gap", 32'(last_hi >= GAP), 32'd1);

        // Continuation across the 16 MB wrap
        do_read("quad_fffffc", 24'hFFFFFC, 1'b1, 66 + GAP);
        falls0 = csb_falls;
        do_read("quad_wrap_00", 24'h000002, 1'b1, 18);
        check("wrap_no_cmd", 32'(csb_falls - falls0), 32'd0);

        // Single-mode continuation
        do_read("single_20", 24'h000020, 1'b0, 130 + GAP);
        do_read("single_cont_24", 24'h000024, 1'b0, 66);

        // Reset in the middle of DATA
        @(negedge clk);
        valid    = 1'b1;
        addr     = 24'h000040;
        cfg_quad = 1'b0;
        wait_cycles(100);
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_csb", 32'(flash_csb), 32'd1);
        check("abort_oe", 32'(flash_io_oe), 32'd0);
        check("abort_fclk", 32'(flash_clk), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(40);
        check("rewake_count", 32'(wake_seen), 32'd2);
        do_read("after_reset_0c", 24'h00000C, 1'b1, 66);

        wait_cycles(5);
        check("ready_pulses", 32'(pulses), 32'(n_reads));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("io_lines", 32'(io_bad), 32'd0);
        check("line_stable_high", 32'(line_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
